// File: rtl/vga_pkg.sv
// Shared VGA timing constants, receiver state encoding and the CRC-16-CCITT step
// used by the optional per-frame checksum.
package vga_pkg;

  localparam int VGA_H_AV    = 640;
  localparam int VGA_H_FP    = 16;
  localparam int VGA_H_SP    = 96;
  localparam int VGA_H_BP    = 48;
  localparam int VGA_V_AV    = 480;
  localparam int VGA_V_FP    = 10;
  localparam int VGA_V_SP    = 2;
  localparam int VGA_V_BP    = 33;

  // Receiver-side view of the driver timing (driver wraps one clock late).
  localparam int VGA_H_TOTAL = 801;
  localparam int VGA_V_TOTAL = 526;
  localparam int VGA_H_START = 145;
  localparam int VGA_V_START = 35;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_t;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_SEED = 16'hFFFF;

  // Shift one pixel (R first) into a CRC-16-CCITT register.
  function automatic logic [15:0] crc16_rgb(input logic [15:0] crc, input logic [2:0] bits);
    logic [15:0] c;
    c = crc;
    for (int i = 2; i >= 0; i--) begin
      if (c[15] ^ bits[i]) c = {c[14:0], 1'b0} ^ CRC_POLY;
      else                 c = {c[14:0], 1'b0};
    end
    return c;
  endfunction

endpackage

// File: rtl/vga_rx_sync.sv
// Two-flop synchronizer for the VGA pins plus falling-edge detection on the
// synchronized hSync/vSync. All flops reset to 1, the idle sync level.
module vga_rx_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hs,
  input  logic         vs,
  input  logic [W-1:0] data,
  output logic [W-1:0] data_sync,
  output logic         h_fall,
  output logic         v_fall
);

  logic [W+1:0] meta;
  logic [W+1:0] stage;
  logic [1:0]   prev;

  // Two-stage capture of all pins, then one more stage on the syncs for edge detect
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta  <= '1;
      stage <= '1;
      prev  <= '1;
    end else begin
      meta  <= {hs, vs, data};
      stage <= meta;
      prev  <= stage[W+1:W];
    end
  end

  assign data_sync = stage[W-1:0];
  assign h_fall    = prev[1] & ~stage[W+1];
  assign v_fall    = prev[0] & ~stage[W];

endmodule

// File: rtl/vga_sync_receiver.sv
// VGA timing receiver / frame checker. Locks onto hSync/vSync timing, recovers
// active-pixel coordinates and reports the lit-pixel count once per clean frame.
// Optional feature: define VGA_RX_CRC_EN to add the frameCrc output.
//
// state   | meaning
// SEARCH  | no timing reference, waiting for a vSync fall
// ACQUIRE | measuring one frame to validate line period and line count
// LOCKED  | timing confirmed; active pixels and frame results are reported
module vga_sync_receiver
  import vga_pkg::*;
#(
  parameter int H_AV    = VGA_H_AV,
  parameter int V_AV    = VGA_V_AV,
  parameter int H_TOTAL = VGA_H_TOTAL,
  parameter int V_TOTAL = VGA_V_TOTAL,
  parameter int H_START = VGA_H_START,
  parameter int V_START = VGA_V_START,
  parameter int H_TOL   = 1,
  parameter int V_TOL   = 1
) (
  input  logic        clk,
  input  logic        resetN,
  input  logic        hSync,
  input  logic        vSync,
  input  logic        R,
  input  logic        G,
  input  logic        B,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        valid,
  output logic [2:0]  rgb,
  output logic        locked,
  output logic        frameDone,
  output logic [18:0] litCount
`ifdef VGA_RX_CRC_EN
  ,
  output logic [15:0] frameCrc
`endif
);

  localparam logic [9:0]  CNT_MAX = 10'h3FF;
  localparam logic [10:0] H_LO    = 11'(H_TOTAL - H_TOL);
  localparam logic [10:0] H_HI    = 11'(H_TOTAL + H_TOL);
  localparam logic [10:0] V_LO    = 11'(V_TOTAL - V_TOL);
  localparam logic [10:0] V_HI    = 11'(V_TOTAL + V_TOL);
  localparam logic [10:0] H_BEG   = 11'(H_START);
  localparam logic [10:0] H_END   = 11'(H_START + H_AV);
  localparam logic [10:0] V_BEG   = 11'(V_START);
  localparam logic [10:0] V_END   = 11'(V_START + V_AV);

  logic [2:0]  rgb_s;
  logic        h_fall, v_fall;
  logic [9:0]  h_cnt, h_cnt_nxt, v_cnt, v_cnt_nxt;
  logic        h_sat;
  logic [10:0] period;
  logic        line_bad, line_err, h_seen;
  logic        v_ok, frame_ok;
  logic        valid_nxt;
  logic [18:0] acc;
  rx_state_t   state, state_nxt;

  vga_rx_sync #(.W(3)) u_sync (
    .clk       (clk),
    .rst_n     (resetN),
    .hs        (hSync),
    .vs        (vSync),
    .data      ({R, G, B}),
    .data_sync (rgb_s),
    .h_fall    (h_fall),
    .v_fall    (v_fall)
  );

  assign h_sat    = (h_cnt == CNT_MAX);
  assign period   = {1'b0, h_cnt} + 11'd1;
  assign line_bad = (period < H_LO) || (period > H_HI);
  assign v_ok     = ({1'b0, v_cnt} >= V_LO) && ({1'b0, v_cnt} <= V_HI);
  assign frame_ok = !line_err && v_ok;
  assign locked   = (state == LOCKED);

  // Next counter values; they describe the pixel now leaving the synchronizer
  always_comb begin
    h_cnt_nxt = h_cnt;
    v_cnt_nxt = v_cnt;
    if (h_fall)      h_cnt_nxt = '0;
    else if (!h_sat) h_cnt_nxt = h_cnt + 10'd1;
    if (v_fall)                          v_cnt_nxt = '0;
    else if (h_fall && v_cnt != CNT_MAX) v_cnt_nxt = v_cnt + 10'd1;
  end

  // Position counters
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      h_cnt <= h_cnt_nxt;
      v_cnt <= v_cnt_nxt;
    end
  end

  // Sticky line-period error; the first line after vSync has no trusted start
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      line_err <= 1'b0;
      h_seen   <= 1'b0;
    end else if (v_fall) begin
      line_err <= 1'b0;
      h_seen   <= 1'b0;
    end else if (h_fall) begin
      h_seen <= 1'b1;
      if (h_seen && line_bad) line_err <= 1'b1;
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) state <= SEARCH;
    else         state <= state_nxt;
  end

  // Lock decisions are taken at vSync falls; a lost hSync drops lock at once
  always_comb begin
    state_nxt = state;
    if (h_sat) begin
      state_nxt = SEARCH;
    end else if (v_fall) begin
      case (state)
        SEARCH:  state_nxt = ACQUIRE;
        ACQUIRE: state_nxt = frame_ok ? LOCKED : ACQUIRE;
        LOCKED:  state_nxt = frame_ok ? LOCKED : SEARCH;
        default: state_nxt = SEARCH;
      endcase
    end
  end

  assign valid_nxt = locked
                   && ({1'b0, h_cnt_nxt} >= H_BEG) && ({1'b0, h_cnt_nxt} < H_END)
                   && ({1'b0, v_cnt_nxt} >= V_BEG) && ({1'b0, v_cnt_nxt} < V_END);

  // Pixel output register
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      x     <= '0;
      y     <= '0;
      valid <= 1'b0;
      rgb   <= '0;
    end else begin
      valid <= valid_nxt;
      x     <= valid_nxt ? h_cnt_nxt - 10'(H_START) : '0;
      y     <= valid_nxt ? v_cnt_nxt - 10'(V_START) : '0;
      rgb   <= rgb_s;
    end
  end

  // Lit-pixel accumulator, published only for frames that were locked and clean
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      acc       <= '0;
      litCount  <= '0;
      frameDone <= 1'b0;
    end else begin
      frameDone <= 1'b0;
      if (v_fall) begin
        acc <= '0;
        if (locked && frame_ok) begin
          litCount  <= acc;
          frameDone <= 1'b1;
        end
      end else if (valid_nxt && |rgb_s) begin
        acc <= acc + 19'd1;
      end
    end
  end

`ifdef VGA_RX_CRC_EN
  logic [15:0] crc_acc;

  // Per-frame CRC over valid pixels, latched together with litCount
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      crc_acc  <= CRC_SEED;
      frameCrc <= '0;
    end else if (v_fall) begin
      crc_acc <= CRC_SEED;
      if (locked && frame_ok) frameCrc <= crc_acc;
    end else if (valid_nxt) begin
      crc_acc <= crc16_rgb(crc_acc, rgb_s);
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_receiver.sv
// Bench for vga_sync_receiver with a scaled-down raster (20 clocks x 8 lines).
module tb_vga_sync_receiver;

  localparam int H_AV  = 8;
  localparam int V_AV  = 4;
  localparam int H_TOT = 20;
  localparam int V_TOT = 8;
  localparam int H_ST  = 5;
  localparam int V_ST  = 2;

  logic clk = 1'b0;
  logic resetN = 1'b0;
  logic hSync = 1'b1, vSync = 1'b1, R = 1'b0, G = 1'b0, B = 1'b0;
  logic [9:0]  x, y;
  logic        valid, locked, frameDone;
  logic [2:0]  rgb;
  logic [18:0] litCount;
`ifdef VGA_RX_CRC_EN
  logic [15:0] frameCrc;
  logic [15:0] crc_q[$];
  logic [15:0] pend_crc = 16'hFFFF;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int done_seen = 0;
  logic [22:0] pix_q[$];
  int lit_q[$];
  bit cur_lock = 1'b0;
  bit pend_ok = 1'b0;
  int pend_lit = 0;

  vga_sync_receiver #(
    .H_AV(H_AV), .V_AV(V_AV), .H_TOTAL(H_TOT), .V_TOTAL(V_TOT),
    .H_START(H_ST), .V_START(V_ST), .H_TOL(1), .V_TOL(1)
  ) dut (
    .clk(clk), .resetN(resetN), .hSync(hSync), .vSync(vSync),
    .R(R), .G(G), .B(B), .x(x), .y(y), .valid(valid), .rgb(rgb),
    .locked(locked), .frameDone(frameDone), .litCount(litCount)
`ifdef VGA_RX_CRC_EN
    , .frameCrc(frameCrc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

`ifdef VGA_RX_CRC_EN
  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic [2:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 2; i >= 0; i--) begin
      r = (r[15] ^ d[i]) ? ({r[14:0], 1'b0} ^ 16'h1021) : {r[14:0], 1'b0};
    end
    return r;
  endfunction
`endif

  // Scoreboard consumer: pixels and frame results
  always @(negedge clk) begin
    if (valid) begin
      if (pix_q.size() == 0) check_eq("valid_extra", 32'(valid), 32'd0);
      else check_eq("pixel", 32'({x, y, rgb}), 32'(pix_q.pop_front()));
    end
    if (frameDone) begin
      done_seen++;
      if (lit_q.size() == 0) check_eq("done_extra", 32'(frameDone), 32'd0);
      else check_eq("lit_count", 32'(litCount), 32'(lit_q.pop_front()));
`ifdef VGA_RX_CRC_EN
      if (crc_q.size() != 0) check_eq("frame_crc", 32'(frameCrc), 32'(crc_q.pop_front()));
`endif
    end
  end

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_x"}, 32'(x), 32'd0);
    check_eq({tag, "_y"}, 32'(y), 32'd0);
    check_eq({tag, "_valid"}, 32'(valid), 32'd0);
    check_eq({tag, "_rgb"}, 32'(rgb), 32'd0);
    check_eq({tag, "_locked"}, 32'(locked), 32'd0);
    check_eq({tag, "_done"}, 32'(frameDone), 32'd0);
    check_eq({tag, "_lit"}, 32'(litCount), 32'd0);
  endtask

  task automatic apply_mid_reset();
    check_eq("pre_rst_valid", 32'(valid), 32'd1);
    resetN = 1'b0;
    #1;
    check_all_zero("mid_rst");
    pix_q.delete();
    @(negedge clk);
    resetN = 1'b1;
  endtask

  // One frame: vSync falls at clock 10 of line 0; hSync low for clocks 0..1
  task automatic run_frame(input int idx, input bit lock_in, input int odd_line,
                           input int odd_per, input bit stall, input bit do_reset);
    bit lk;
    bit clean;
    int lit;
    int len;
    int drop_at;
    logic [2:0] pat;
`ifdef VGA_RX_CRC_EN
    logic [15:0] crc;
    crc = 16'hFFFF;
`endif
    lk = lock_in;
    lit = 0;
    drop_at = -1;
    for (int lc = 0; lc < V_TOT; lc++) begin
      len = (lc == odd_line) ? odd_per : H_TOT;
      if (stall && lc == V_TOT - 1) len = 1100;
      for (int hc = 0; hc < len; hc++) begin
        @(posedge clk);
        #1;
        hSync = (hc >= 2);
        pat = 3'((hc * 3 + lc * 5 + idx) % 8);
        {R, G, B} = pat;
        if (lc == 0 && hc == 10) begin
          vSync = 1'b0;
          if (pend_ok) begin
            lit_q.push_back(pend_lit);
`ifdef VGA_RX_CRC_EN
            crc_q.push_back(pend_crc);
`endif
          end
          pend_ok = 1'b0;
        end
        if (lc == 1 && hc == 10) vSync = 1'b1;
        if (lc == 0 && hc == 12) check_eq("lock_before_fall", 32'(locked), 32'(cur_lock));
        if (lc == 0 && hc == 13) check_eq("lock_after_fall", 32'(locked), 32'(lock_in));
        if (hc >= H_ST && hc < H_ST + H_AV && lc >= V_ST && lc < V_ST + V_AV) begin
          if (pat != 3'd0) lit++;
`ifdef VGA_RX_CRC_EN
          crc = crc_step(crc, pat);
`endif
          if (lk) pix_q.push_back({10'(hc - H_ST), 10'(lc - V_ST), pat});
        end
        if (stall && lc == V_TOT - 1 && drop_at < 0 && locked == 1'b0) drop_at = hc;
        if (do_reset && lc == 3 && hc == 8) begin
          apply_mid_reset();
          lk = 1'b0;
        end
      end
    end
    if (stall) check_eq("stall_drop", 32'(drop_at), 32'd1027);
    clean = (odd_line < 0) || (odd_per >= H_TOT - 1 && odd_per <= H_TOT + 1);
    pend_ok = lk && clean && !stall && !do_reset;
    pend_lit = lit;
`ifdef VGA_RX_CRC_EN
    pend_crc = crc;
`endif
    cur_lock = lk && !stall;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    resetN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk);
    resetN = 1'b1;

    //        idx lock odd_line odd_per stall reset
    run_frame(0,  0,   -1,      0,      0,    0);
    run_frame(1,  1,   3,       19,     0,    0);
    run_frame(2,  1,   4,       21,     0,    0);
    run_frame(3,  1,   4,       22,     0,    0);
    run_frame(4,  0,   -1,      0,      0,    0);
    run_frame(5,  0,   -1,      0,      0,    0);
    run_frame(6,  1,   -1,      0,      0,    0);
    run_frame(7,  1,   -1,      0,      1,    0);
    run_frame(8,  0,   -1,      0,      0,    0);
    run_frame(9,  1,   -1,      0,      0,    0);
    run_frame(10, 1,   -1,      0,      0,    1);
    run_frame(11, 0,   -1,      0,      0,    0);
    run_frame(12, 1,   -1,      0,      0,    0);
    run_frame(13, 1,   -1,      0,      0,    0);
    run_frame(14, 1,   -1,      0,      0,    0);

    repeat (5) @(posedge clk);
    #1;
    check_eq("done_count", 32'(done_seen), 32'd6);
    check_eq("pix_left", 32'(pix_q.size()), 32'd0);
    check_eq("lit_left", 32'(lit_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
